id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Parametrised RV32I instruction-decode pipeline stage between IF and EX.
- Decodes the instruction and generates the sign-extended immediate.
- Drives register-file read addresses and captures the returned operands.
- Registers everything into an ID/EX pipeline register with a valid/ready handshake on both sides.
- Load-use hazard detection inserts bubbles; flush support for taken branches and jumps.

Parameters:
- XLEN, 32: datapath width; immediates sign-extended to XLEN.
- REG_AW, 5: register address width.
- CTRL_W, 16: width of the packed control word (fields fixed in the package).

Ports:
- clk, in, 1: clock, rising edge.
- res, in, 1: asynchronous active-high reset.
- if_valid, in, 1: IF presents an instruction.
- if_ready, out, 1: ID accepts the instruction this cycle.
- if_pc, in, XLEN: PC of the instruction.
- if_instr, in, 32: instruction word.
- rs1_addr, out, REG_AW: regfile read address 1; combinational from if_instr[19:15].
- rs2_addr, out, REG_AW: regfile read address 2; combinational from if_instr[24:20].
- rs1_data, in, XLEN: same-cycle read data 1 (regfile is write-first).
- rs2_data, in, XLEN: same-cycle read data 2.
- ex_load_valid, in, 1: instruction currently in EX is a load.
- ex_load_rd, in, REG_AW: destination of that load.
- flush, in, 1: kill the ID/EX contents and the current IF instruction.
- ex_valid, out, 1: ID/EX register holds a valid instruction.
- ex_ready, in, 1: EX accepts this cycle.
- ex_ctrl, out, CTRL_W: packed control word.
- ex_pc, out, XLEN.
- ex_rs1, out, XLEN.
- ex_rs2, out, XLEN.
- ex_imm, out, XLEN.
- ex_rd, out, REG_AW.
- ex_illegal, out, 1: undecodable opcode.

Behaviour:
- Reset (async, immediate):
  - ex_valid=0 and ex_illegal=0.
  - ex_ctrl, ex_pc, ex_rs1, ex_rs2, ex_imm and ex_rd all 0.
- advance = !ex_valid || ex_ready.
- hazard = ex_load_valid && ex_load_rd!=0 && ((uses_rs1 && rs1_addr==ex_load_rd) || (uses_rs2 && rs2_addr==ex_load_rd)).
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
- if_ready = advance && !hazard && !flush (combinational).
- Priority at each clk edge:
  1. flush: ex_valid<=0; data registers hold.
  2. else if advance && hazard: ex_valid<=0 (bubble); instruction stays in IF.
  3. else if advance: ex_valid<=if_valid; data registers load the decode of if_instr.
  4. else: hold all outputs unchanged.
- Latency: 1 cycle from acceptance to ex_valid.
- Throughput: 1 instruction per cycle when there is no stall.
- Opcode decode (instr[6:0]):
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, LOAD 0000011, STORE 0100011
  - OP-IMM 0010011, OP 0110011
- Immediates:
  - I: instr[31:20].
  - S: {31:25, 11:7}.
  - B: {31, 7, 30:25, 11:8, 0}.
  - U: {31:12, 12'b0}.
  - J: {31, 19:12, 20, 30:21, 0}.
  - All sign-extended from instr[31] to XLEN.
  - R-type imm=0.
- ALU op:
  - OP: from funct3 plus funct7[5] (SUB/SRA).
  - OP-IMM: funct7[5] is honoured only for SRAI; SUB is never produced.
  - LOAD, STORE, AUIPC, JAL, JALR: ADD.
  - LUI: PASS_B.
  - BRANCH: cmp field = funct3.
- reg_wr forced 0 when rd==0, and for STORE and BRANCH.
- Any other opcode:
  - ex_illegal=1 travels with the instruction.
  - ctrl is a NOP (all enables 0).
  - ex_valid still asserts so EX can trap.
- Reset mid-stall or mid-backpressure: all state cleared; no instruction is replayed by ID.
- flush concurrent with if_valid: the IF instruction is not accepted (if_ready=0).

Decomposition:
- Package id_pkg holds:
  - Opcode constants.
  - alu_op_e, 4 bits: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
  - ctrl_t field layout:
    - alu_op[3:0]
    - a_sel[5:4] (0 rs1, 1 pc, 2 zero)
    - b_imm[6]
    - mem_rd[7], mem_wr[8], mem_size[11:9] (funct3)
    - reg_wr[12], branch[13], jump[14], jalr[15]
  - imm_type_e.
- One sub-module, id_imm_gen: combinational; takes the instruction and immediate type, returns the XLEN immediate.
- Decode logic, hazard logic and the pipeline register live in id_stage.

Test Plan:
- addi x1,x0,5 (0x00500093), if_valid=1, ex_ready=1 -> next cycle:
  - ex_valid=1, ex_imm=5, ex_rd=1.
  - alu_op=ADD, b_imm=1, reg_wr=1.
- beq x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, branch=1, reg_wr=0, rs1_addr=rs2_addr=0.
- Load-use: ex_load_valid=1, ex_load_rd=1, if_instr=add x2,x1,x1 (0x00108133):
  - if_ready=0, and ex_valid=0 on the next edge.
  - Drop ex_load_valid -> accepted next cycle with ex_rd=2.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles -> if_ready=0 and all ex_* outputs stable; ex_ready=1 -> next instruction loads.
- flush=1 with ex_valid=1 and if_valid=1 -> if_ready=0, ex_valid=0 next cycle; reg_wr of the killed instruction never seen.
- Illegal 0xFFFFFFFF -> ex_valid=1, ex_illegal=1, ctrl=0.
- Reset: assert res mid-stream -> outputs zero immediately (asynchronously).

Source files
------------

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - RV32I decode constants, control-word layout and ALU op helpers
package id_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Packed MSB-first so that alu_op lands in bits [3:0] and jalr in bit 15.
  typedef struct packed {
    logic       jalr;
    logic       jump;
    logic       branch;
    logic       reg_wr;
    logic [2:0] mem_size;
    logic       mem_wr;
    logic       mem_rd;
    logic       b_imm;
    a_sel_e     a_sel;
    alu_op_e    alu_op;
  } ctrl_t;

  // alt selects SUB/SRA; callers decide whether funct7[5] is allowed to reach it.
  function automatic alu_op_e alu_from_f3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - IF/regfile/EX-facing signal bundle of the decode stage
interface id_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
);
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [31:0]       if_instr;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              ex_load_valid;
  logic [REG_AW-1:0] ex_load_rd;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1;
  logic [XLEN-1:0]   ex_rs2;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_illegal;

  modport slave (
    input  if_valid, if_pc, if_instr, rs1_data, rs2_data,
           ex_load_valid, ex_load_rd, flush, ex_ready,
    output if_ready, rs1_addr, rs2_addr, ex_valid, ex_ctrl,
           ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_illegal
  );

  modport master (
    output if_valid, if_pc, if_instr, rs1_data, rs2_data,
           ex_load_valid, ex_load_rd, flush, ex_ready,
    input  if_ready, rs1_addr, rs2_addr, ex_valid, ex_ctrl,
           ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_illegal
  );
endinterface

// File: rtl/id_imm_gen.sv
// rtl/id_imm_gen.sv - combinational RV32I immediate extraction, sign-extended to XLEN
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (imm_type)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // raw already carries the sign in bit 31; widening keeps it for XLEN > 32.
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with load-use stall, flush and ID/EX register
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
) (
  input logic       clk,
  input logic       res,
  id_stage_if.slave bus
);

  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              f7_alt;
  logic [REG_AW-1:0] rs1_a;
  logic [REG_AW-1:0] rs2_a;
  logic [REG_AW-1:0] rd_a;

  ctrl_t             ctrl;
  imm_type_e         imm_type;
  logic              illegal;
  logic              uses_rs1;
  logic              uses_rs2;
  logic [XLEN-1:0]   imm;

  logic              advance;
  logic              hazard;

  logic              ex_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [XLEN-1:0]   ex_pc_q;
  logic [XLEN-1:0]   ex_rs1_q;
  logic [XLEN-1:0]   ex_rs2_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_illegal_q;

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7_alt = instr[30];
  assign rs1_a  = REG_AW'(instr[19:15]);
  assign rs2_a  = REG_AW'(instr[24:20]);
  assign rd_a   = REG_AW'(instr[11:7]);

  assign bus.rs1_addr = rs1_a;
  assign bus.rs2_addr = rs2_a;

  always_comb begin
    ctrl     = '0;
    imm_type = IMM_R;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.alu_op = ALU_PASS_B;
        ctrl.a_sel  = A_ZERO;
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        imm_type    = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.a_sel  = A_PC;
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        imm_type    = IMM_U;
      end
      OPC_JAL: begin
        ctrl.a_sel  = A_PC;
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.jump   = 1'b1;
        imm_type    = IMM_J;
      end
      OPC_JALR: begin
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.jump   = 1'b1;
        ctrl.jalr   = 1'b1;
        imm_type    = IMM_I;
        uses_rs1    = 1'b1;
      end
      OPC_BRANCH: begin
        // EX reads the comparison kind straight from funct3 in the alu_op field.
        ctrl.alu_op = alu_op_e'({1'b0, funct3});
        ctrl.branch = 1'b1;
        imm_type    = IMM_B;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.b_imm    = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.mem_size = funct3;
        ctrl.reg_wr   = 1'b1;
        imm_type      = IMM_I;
        uses_rs1      = 1'b1;
      end
      OPC_STORE: begin
        ctrl.b_imm    = 1'b1;
        ctrl.mem_wr   = 1'b1;
        ctrl.mem_size = funct3;
        imm_type      = IMM_S;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_OP_IMM: begin
        // Bit 30 is immediate data except for SRAI, so ADDI never becomes SUB.
        ctrl.alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && f7_alt);
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        imm_type    = IMM_I;
        uses_rs1    = 1'b1;
      end
      OPC_OP: begin
        ctrl.alu_op = alu_from_f3(funct3, f7_alt);
        ctrl.reg_wr = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (rd_a == '0) ctrl.reg_wr = 1'b0;
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (instr[31:7]),
    .imm_type (imm_type),
    .imm      (imm)
  );

  assign advance = !ex_valid_q || bus.ex_ready;
  assign hazard  = bus.ex_load_valid && (bus.ex_load_rd != '0) &&
                   ((uses_rs1 && (rs1_a == bus.ex_load_rd)) ||
                    (uses_rs2 && (rs2_a == bus.ex_load_rd)));
  assign bus.if_ready = advance && !hazard && !bus.flush;

  // Flush and bubbles only clear valid; the payload is don't-care while invalid.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_illegal_q <= 1'b0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance && hazard) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      ex_valid_q   <= bus.if_valid;
      ex_ctrl_q    <= CTRL_W'(ctrl);
      ex_pc_q      <= bus.if_pc;
      ex_rs1_q     <= bus.rs1_data;
      ex_rs2_q     <= bus.rs2_data;
      ex_imm_q     <= imm;
      ex_rd_q      <= rd_a;
      ex_illegal_q <= illegal;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_rs1     = ex_rs1_q;
  assign bus.ex_rs2     = ex_rs2_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed and randomized checks of id_stage against a reference model
module tb_id_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) bus ();

  id_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic        m_ill;
  logic [15:0] m_ctrl;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  logic        last_rdy;

  logic [3:0] f3_alu [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    s = i;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        hi = s >>> 20;
        return hi;
      end
      7'b0100011: begin
        hi = s >>> 25;
        return (hi << 5) | 32'(i[11:7]);
      end
      7'b1100011: begin
        hi = s >>> 31;
        return (hi << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
      7'b1101111: begin
        hi = s >>> 31;
        return (hi << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [31:0] i);
    for (int k = 0; k < 9; k++) if (i[6:0] == legal_ops[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] ref_ctrl(input logic [31:0] i);
    logic lui, auipc, jal, jalr, br, ld, st, opi, op, legal, bimm, rw;
    logic [3:0] alu;
    logic [1:0] asel;
    logic [2:0] f3, msz;
    lui = i[6:0] == 7'b0110111;  auipc = i[6:0] == 7'b0010111;
    jal = i[6:0] == 7'b1101111;  jalr  = i[6:0] == 7'b1100111;
    br  = i[6:0] == 7'b1100011;  ld    = i[6:0] == 7'b0000011;
    st  = i[6:0] == 7'b0100011;  opi   = i[6:0] == 7'b0010011;
    op  = i[6:0] == 7'b0110011;
    legal = ref_legal(i);
    f3 = i[14:12];
    if (op || opi) begin
      alu = f3_alu[f3];
      if (f3 == 3'd5 && i[30]) alu = 4'd7;
      if (op && f3 == 3'd0 && i[30]) alu = 4'd1;
    end else if (br) alu = {1'b0, f3};
    else if (lui) alu = 4'd10;
    else alu = 4'd0;
    asel = lui ? 2'd2 : ((auipc || jal) ? 2'd1 : 2'd0);
    bimm = legal && !op && !br;
    msz  = (ld || st) ? f3 : 3'd0;
    rw   = legal && !st && !br && (i[11:7] != 5'd0);
    return {jalr, jal || jalr, br, rw, msz, st, ld, bimm, asel, alu};
  endfunction

  function automatic logic ref_hazard(input logic [31:0] i, input logic lv, input logic [4:0] lrd);
    logic u1, u2;
    u1 = i[6:0] inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    u2 = i[6:0] inside {7'b1100011, 7'b0100011, 7'b0110011};
    return lv && lrd != 5'd0 && ((u1 && i[19:15] == lrd) || (u2 && i[24:20] == lrd));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_ctrl = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".ex_valid"},   bus.ex_valid,   m_valid);
    chk({ph, ".ex_ctrl"},    bus.ex_ctrl,    m_ctrl);
    chk({ph, ".ex_pc"},      bus.ex_pc,      m_pc);
    chk({ph, ".ex_rs1"},     bus.ex_rs1,     m_rs1);
    chk({ph, ".ex_rs2"},     bus.ex_rs2,     m_rs2);
    chk({ph, ".ex_imm"},     bus.ex_imm,     m_imm);
    chk({ph, ".ex_rd"},      bus.ex_rd,      m_rd);
    chk({ph, ".ex_illegal"}, bus.ex_illegal, m_ill);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy,
                       input logic lv, input logic [4:0] lrd, input logic fl);
    bus.if_valid = v;  bus.if_instr = ins;  bus.ex_ready = rdy;
    bus.ex_load_valid = lv;  bus.ex_load_rd = lrd;  bus.flush = fl;
    bus.if_pc = $urandom() & 32'hFFFF_FFFC;
    bus.rs1_data = $urandom();
    bus.rs2_data = $urandom();
  endtask

  task automatic cycle(input string ph);
    logic adv, hz;
    #2;
    adv = !m_valid || bus.ex_ready;
    hz  = ref_hazard(bus.if_instr, bus.ex_load_valid, bus.ex_load_rd);
    last_rdy = bus.if_ready;
    chk({ph, ".if_ready"}, bus.if_ready, adv && !hz && !bus.flush);
    chk({ph, ".rs1_addr"}, bus.rs1_addr, bus.if_instr[19:15]);
    chk({ph, ".rs2_addr"}, bus.rs2_addr, bus.if_instr[24:20]);
    if (bus.flush) m_valid = 0;
    else if (adv && hz) m_valid = 0;
    else if (adv) begin
      m_valid = bus.if_valid;
      m_ctrl  = ref_ctrl(bus.if_instr);
      m_imm   = ref_imm(bus.if_instr);
      m_ill   = !ref_legal(bus.if_instr);
      m_rd    = bus.if_instr[11:7];
      m_pc    = bus.if_pc;
      m_rs1   = bus.rs1_data;
      m_rs2   = bus.rs2_data;
    end
    @(posedge clk);
    #1;
    check_outputs(ph);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  o;
    r = $urandom();
    o = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : legal_ops[$urandom_range(0, 8)];
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    return {r[31:7], o};
  endfunction

  initial begin
    res = 1'b1;
    drive(0, 32'h0000_0013, 1, 0, 0, 0);
    model_reset();
    #1;
    check_outputs("reset_async");
    @(posedge clk); #1;
    res = 1'b0;

    drive(1, 32'h0050_0093, 1, 0, 0, 0);
    cycle("addi");
    chk("addi.valid", bus.ex_valid, 1);
    chk("addi.imm", bus.ex_imm, 32'd5);
    chk("addi.rd", bus.ex_rd, 5'd1);
    chk("addi.alu", bus.ex_ctrl[3:0], 4'd0);
    chk("addi.b_imm", bus.ex_ctrl[6], 1);
    chk("addi.reg_wr", bus.ex_ctrl[12], 1);

    drive(1, 32'hFE00_0EE3, 1, 0, 0, 0);
    cycle("beq");
    chk("beq.imm", bus.ex_imm, 32'hFFFF_FFFC);
    chk("beq.branch", bus.ex_ctrl[13], 1);
    chk("beq.reg_wr", bus.ex_ctrl[12], 0);

    drive(1, 32'h0010_8133, 1, 1, 5'd1, 0);
    cycle("loaduse");
    chk("loaduse.if_ready", last_rdy, 0);
    chk("loaduse.bubble", bus.ex_valid, 0);
    bus.ex_load_valid = 0;
    cycle("loaduse_go");
    chk("loaduse_go.valid", bus.ex_valid, 1);
    chk("loaduse_go.rd", bus.ex_rd, 5'd2);

    drive(1, 32'h0030_0193, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle("bp_hold");
      chk("bp_hold.if_ready", last_rdy, 0);
      chk("bp_hold.rd", bus.ex_rd, 5'd2);
    end
    bus.ex_ready = 1;
    cycle("bp_release");
    chk("bp_release.rd", bus.ex_rd, 5'd3);

    drive(1, 32'h0010_8133, 1, 0, 0, 1);
    cycle("flush");
    chk("flush.if_ready", last_rdy, 0);
    chk("flush.valid", bus.ex_valid, 0);
    drive(0, 32'h0000_0013, 1, 0, 0, 0);
    cycle("flush_after");
    chk("flush_after.valid", bus.ex_valid, 0);

    drive(1, 32'hFFFF_FFFF, 1, 0, 0, 0);
    cycle("illegal");
    chk("illegal.valid", bus.ex_valid, 1);
    chk("illegal.flag", bus.ex_illegal, 1);
    chk("illegal.ctrl", bus.ex_ctrl, 16'd0);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
      cycle("rand");
    end

    drive(1, 32'h0050_0093, 1, 0, 0, 0);
    cycle("pre_stall");
    drive(1, 32'h0010_8133, 0, 1, 5'd1, 0);
    cycle("stall");
    res = 1'b1;
    model_reset();
    #1;
    check_outputs("reset_mid");
    @(posedge clk); #1;
    res = 1'b0;
    drive(0, 32'h0010_8133, 1, 0, 0, 0);
    cycle("no_replay");
    chk("no_replay.valid", bus.ex_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
